// File: rtl/pong_pkg.sv
// Shared state encoding and default timing/score constants for the pong match controller.
package pong_pkg;

    localparam int DEF_WIN_SCORE    = 11;
    localparam int DEF_SERVE_FRAMES = 60;
    localparam int DEF_POINT_FRAMES = 30;
    localparam int SCORE_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_PLAY,
        ST_PAUSE,
        ST_POINT,
        ST_GAME_OVER
    } state_t;

endpackage

// File: rtl/pong_edge_det.sv
// Registered rising-edge detector: rise pulses for one cycle, one cycle after d goes 0->1.
module pong_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Sample the input and flag a 0->1 transition against the previous sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match controller for pong: serve/play/pause/point sequencing, scoring and game-over decision.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int POINT_FRAMES = DEF_POINT_FRAMES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               point_l,
    input  logic               point_r,
    output logic               ball_run,
    output logic               ball_center,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner
);

    localparam logic [SCORE_W-1:0] WIN_V   = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         SERVE_V = 8'(SERVE_FRAMES);
    localparam logic [7:0]         POINT_V = 8'(POINT_FRAMES);

    logic frame_tick;
    logic start_evt;
    logic pause_evt;

    state_t             state, state_n;
    logic [7:0]         cnt, cnt_n;
    logic [SCORE_W-1:0] score_l_n, score_r_n;
    logic               serve_dir_n;
    logic               winner_n;

    // Scores stop at the top of their range instead of wrapping back to zero.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    pong_edge_det u_vsync_det (.clk(clk), .reset(reset), .d(vsync),     .rise(frame_tick));
    pong_edge_det u_start_det (.clk(clk), .reset(reset), .d(start_btn), .rise(start_evt));
    pong_edge_det u_pause_det (.clk(clk), .reset(reset), .d(pause_btn), .rise(pause_evt));

    // Next-state and next-datapath decisions; everything holds unless an event moves it.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        score_l_n   = score_l;
        score_r_n   = score_r;
        serve_dir_n = serve_dir;
        winner_n    = winner;
        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_evt) begin
                    score_l_n   = '0;
                    score_r_n   = '0;
                    serve_dir_n = 1'b1;
                    cnt_n       = SERVE_V;
                    state_n     = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    cnt_n = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
                    if (cnt <= 8'd1) state_n = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // A point outranks a simultaneous pause; left outranks right.
                if (point_l) begin
                    score_l_n   = sat_inc(score_l);
                    serve_dir_n = 1'b1;
                    cnt_n       = POINT_V;
                    state_n     = ST_POINT;
                end else if (point_r) begin
                    score_r_n   = sat_inc(score_r);
                    serve_dir_n = 1'b0;
                    cnt_n       = POINT_V;
                    state_n     = ST_POINT;
                end else if (pause_evt) begin
                    state_n = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_evt) state_n = ST_PLAY;
            end
            ST_POINT: begin
                if (frame_tick) begin
                    if (cnt <= 8'd1) begin
                        if (score_l == WIN_V || score_r == WIN_V) begin
                            // serve_dir points away from the last scorer's side.
                            winner_n = ~serve_dir;
                            cnt_n    = 8'd0;
                            state_n  = ST_GAME_OVER;
                        end else begin
                            cnt_n   = SERVE_V;
                            state_n = ST_SERVE;
                        end
                    end else begin
                        cnt_n = cnt - 8'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, datapath and registered output decodes (taken from the next state so they align).
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            score_l     <= '0;
            score_r     <= '0;
            serve_dir   <= 1'b1;
            winner      <= 1'b0;
            ball_run    <= 1'b0;
            ball_center <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            score_l     <= score_l_n;
            score_r     <= score_r_n;
            serve_dir   <= serve_dir_n;
            winner      <= winner_n;
            ball_run    <= (state_n == ST_PLAY);
            ball_center <= (state_n == ST_IDLE) || (state_n == ST_SERVE);
            game_over   <= (state_n == ST_GAME_OVER);
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench: an action-level match model predicts each visible output change.
module tb_pong_match_ctrl;

    localparam int WIN   = 11;
    localparam int SERVE = 60;
    localparam int POINT = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       vsync = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       point_l = 1'b0;
    logic       point_r = 1'b0;
    logic       ball_run, ball_center, serve_dir, game_over, winner;
    logic [7:0] score_l, score_r;

    pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT)) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .start_btn(start_btn), .pause_btn(pause_btn),
        .point_l(point_l), .point_r(point_r), .ball_run(ball_run), .ball_center(ball_center),
        .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r), .game_over(game_over),
        .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [20:0] t;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur_id = 0;
    bit   mon_en = 1'b0;
    logic [20:0] mon_prev;

    // Behavioural match model: phase names, counters and scores as plain integers.
    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_PAUSE = 3, P_POINT = 4, P_OVER = 5;
    int phase, frames_left, sl, sr, last_scorer;
    bit dir, won_by;
    logic [20:0] m_prev;

    function automatic logic [20:0] dut_t();
        return {ball_run, ball_center, serve_dir, score_l, score_r, game_over, winner};
    endfunction

    function automatic logic [20:0] model_t();
        logic [7:0] a, b;
        a = 8'(sl);
        b = 8'(sr);
        return {phase == P_PLAY, phase == P_IDLE || phase == P_SERVE, dir, a, b,
                phase == P_OVER, won_by};
    endfunction

    task automatic model_reset();
        phase = P_IDLE; frames_left = 0; sl = 0; sr = 0; dir = 1'b1; won_by = 1'b0; last_scorer = 0;
    endtask

    task automatic push_if_changed();
        logic [20:0] t;
        exp_t e;
        t = model_t();
        if (t !== m_prev) begin
            e.t = t;
            e.id = cur_id;
            exp_q.push_back(e);
            m_prev = t;
        end
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic act_reset();
        @(negedge clk);
        cur_id++;
        model_reset();
        push_if_changed();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(3);
    endtask

    task automatic act_vsync();
        @(negedge clk);
        cur_id++;
        if (phase == P_SERVE) begin
            frames_left--;
            if (frames_left == 0) phase = P_PLAY;
        end else if (phase == P_POINT) begin
            frames_left--;
            if (frames_left == 0) begin
                if (sl == WIN || sr == WIN) begin
                    phase = P_OVER;
                    won_by = (last_scorer == 1);
                end else begin
                    phase = P_SERVE;
                    frames_left = SERVE;
                end
            end
        end
        push_if_changed();
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        idle(3);
    endtask

    task automatic act_start();
        @(negedge clk);
        cur_id++;
        if (phase == P_IDLE || phase == P_OVER) begin
            sl = 0; sr = 0; dir = 1'b1; frames_left = SERVE; phase = P_SERVE;
        end
        push_if_changed();
        start_btn = 1'b1;
        idle(2);
        start_btn = 1'b0;
        idle(3);
    endtask

    task automatic act_pause();
        @(negedge clk);
        cur_id++;
        if (phase == P_PLAY) phase = P_PAUSE;
        else if (phase == P_PAUSE) phase = P_PLAY;
        push_if_changed();
        pause_btn = 1'b1;
        idle(2);
        pause_btn = 1'b0;
        idle(3);
    endtask

    // Point pulse, optionally landing in the same cycle as a pause event.
    task automatic act_point(bit l, bit r, bit with_pause);
        @(negedge clk);
        cur_id++;
        if (phase == P_PLAY && (l || r)) begin
            if (l) begin
                sl = (sl < 255) ? sl + 1 : 255; dir = 1'b1; last_scorer = 0;
            end else begin
                sr = (sr < 255) ? sr + 1 : 255; dir = 1'b0; last_scorer = 1;
            end
            phase = P_POINT;
            frames_left = POINT;
        end else if (with_pause) begin
            if (phase == P_PLAY) phase = P_PAUSE;
            else if (phase == P_PAUSE) phase = P_PLAY;
        end
        push_if_changed();
        if (with_pause) begin
            pause_btn = 1'b1;
            @(negedge clk);
        end
        point_l = l;
        point_r = r;
        @(negedge clk);
        point_l = 1'b0;
        point_r = 1'b0;
        pause_btn = 1'b0;
        idle(3);
    endtask

    task automatic vsyncs(int n);
        for (int i = 0; i < n; i++) act_vsync();
    endtask

    // Monitor: every visible output change must match the next predicted change and its action.
    always @(negedge clk) begin
        logic [20:0] cur;
        exp_t e;
        if (mon_en) begin
            cur = dut_t();
            if (cur !== mon_prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change act=%0d got=%h required_no_change_from=%h",
                             cur_id, cur, mon_prev);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t !== cur || e.id != cur_id) begin
                        n_bad++;
                        $display("FAIL output_change act=%0d got=%h required=%h (expected in act %0d)",
                                 cur_id, cur, e.t, e.id);
                    end
                end
                mon_prev = cur;
            end
        end
    end

    initial begin
        int r;
        model_reset();
        m_prev = model_t();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        n_cmp++;
        if (dut_t() !== model_t()) begin
            n_bad++;
            $display("FAIL reset_state got=%h required=%h", dut_t(), model_t());
        end
        mon_prev = model_t();
        mon_en = 1'b1;

        // Serve timing, start ignored while serving/playing, right-side point and re-serve.
        act_start();
        vsyncs(SERVE - 1);
        act_start();
        act_vsync();
        act_start();
        act_point(1'b0, 1'b1, 1'b0);
        act_point(1'b1, 1'b0, 1'b0);
        vsyncs(POINT);
        vsyncs(SERVE);

        // Simultaneous points in a fresh match: left wins the tie.
        act_reset();
        act_start();
        vsyncs(SERVE);
        act_point(1'b1, 1'b1, 1'b0);
        vsyncs(POINT + SERVE);

        // Pause freezes play and ignores points; a point beats a simultaneous pause.
        act_pause();
        act_point(1'b1, 1'b0, 1'b0);
        act_point(1'b0, 1'b1, 1'b0);
        vsyncs(3);
        act_pause();
        act_point(1'b0, 1'b1, 1'b1);
        vsyncs(POINT + SERVE);

        // Left reaches the winning score; then restart from game over.
        while (sl < WIN) begin
            act_point(1'b1, 1'b0, 1'b0);
            vsyncs(POINT);
            if (phase == P_SERVE) vsyncs(SERVE);
        end
        act_point(1'b0, 1'b1, 1'b0);
        act_start();

        // Reset in the middle of a point countdown.
        vsyncs(SERVE);
        act_point(1'b0, 1'b1, 1'b0);
        vsyncs(10);
        act_reset();

        // Randomized play.
        for (int k = 0; k < 1500; k++) begin
            r = $urandom_range(0, 99);
            if (r < 72) act_vsync();
            else if (r < 86) act_point(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                       ($urandom_range(0, 4) == 0));
            else if (r < 93) act_pause();
            else if (r < 99) act_start();
            else act_reset();
        end

        idle(4);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_changes got=%0d left required=0", exp_q.size());
        end
        n_cmp++;
        if (dut_t() !== model_t()) begin
            n_bad++;
            $display("FAIL final_state got=%h required=%h", dut_t(), model_t());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 11, points needed to win a match (1..255).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, frames the ball is held before each serve (1..255).
REQ-003 SHALL have parameter POINT_FRAMES, default 30, frames the display is frozen after a point (1..255).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port vsync, input, 1, vertical sync from the sync generator; one frame elapses per rising edge.
REQ-007 SHALL have port start_btn, input, 1, level-sensitive start button.
REQ-008 SHALL have port pause_btn, input, 1, level-sensitive pause button.
REQ-009 SHALL have port point_l, input, 1, one-cycle pulse from the ball datapath: left player scored.
REQ-010 SHALL have port point_r, input, 1, one-cycle pulse from the ball datapath: right player scored.
REQ-011 SHALL have port ball_run, output, 1, high only while the ball datapath may move the ball.
REQ-012 SHALL have port ball_center, output, 1, high while the datapath must hold the ball at screen centre.
REQ-013 SHALL have port serve_dir, output, 1, initial ball direction (0 = toward left, 1 = toward right).
REQ-014 SHALL have ports score_l and score_r, output, 8 bits each, binary match scores.
REQ-015 SHALL have port game_over, output, 1, high in GAME_OVER state.
REQ-016 SHALL have port winner, output, 1, valid while game_over (0 = left, 1 = right).

Function
REQ-017 SHALL register vsync, start_btn and pause_btn and act only on their 0->1 edges (frame_tick, start_evt, pause_evt), one cycle after the edge.
REQ-018 SHALL implement states IDLE, SERVE, PLAY, PAUSE, POINT, GAME_OVER.
REQ-019 IDLE: ball_center=1, ball_run=0; on start_evt, clear both scores, set serve_dir=1, load the frame counter with SERVE_FRAMES, and go to SERVE.
REQ-020 SERVE: ball_center=1; decrement the counter on each frame_tick; on the tick that reaches 0, go to PLAY on the next cycle.
REQ-021 PLAY: ball_run=1; point_l increments score_l, sets serve_dir=1 and goes to POINT; point_r increments score_r, sets serve_dir=0 and goes to POINT.
REQ-022 SHALL give point_l priority if point_l and point_r assert in the same cycle; point_r is then discarded.
REQ-023 SHALL ignore point pulses in every state except PLAY.
REQ-024 PLAY: on pause_evt, go to PAUSE with ball_run=0; PAUSE: on pause_evt, return to PLAY; PAUSE holds counter and scores frozen.
REQ-025 A pause_evt in the same cycle as an accepted point SHALL be ignored; the point wins.
REQ-026 Entry to POINT: load the counter with POINT_FRAMES; ball_run=0, ball_center=0; count down on frame_tick.
REQ-027 POINT, at count 0: if either score equals WIN_SCORE, go to GAME_OVER with winner = the side that scored; otherwise load SERVE_FRAMES and go to SERVE.
REQ-028 Score increments SHALL saturate at 255 and never wrap.
REQ-029 GAME_OVER: game_over=1; scores and winner are held; on start_evt, clear scores, set serve_dir=1, load SERVE_FRAMES and go to SERVE.
REQ-030 start_evt SHALL be ignored in SERVE, PLAY, PAUSE and POINT.
REQ-031 ball_run, ball_center and game_over SHALL be registered decodes of the state with no combinational path from any input.

Reset
REQ-032 reset SHALL force IDLE, scores 0, serve_dir 1, winner 0, counter 0, edge registers 0, ball_run 0, ball_center 1 and game_over 0 on the next edge, from any state and mid-countdown.

Structure
REQ-033 The state encoding and the default frame constants SHALL live in a shared package pong_pkg.
REQ-034 A sub-module pong_edge_det (registered rising-edge detector) SHALL be instantiated three times; there are no other sub-modules.

Verification
REQ-035 Apply reset, then a start pulse, then 60 vsync edges -> SERVE holds ball_center=1 for 60 frames; ball_run=1 exactly one cycle after the 60th tick is acted on; serve_dir=1.
REQ-036 In PLAY, pulse point_r -> score_r=1, serve_dir=0, ball_run=0; POINT lasts 30 frames, then SERVE starts.
REQ-037 Assert point_l and point_r in the same cycle -> score_l=1 and score_r=0.
REQ-038 Build score_l to 10 and then score the 11th point -> after 30 frames game_over=1 and winner=0; a further start pulse -> scores 0 and state SERVE.
REQ-039 Pause edge in PLAY -> ball_run=0 and point pulses are ignored; a second pause edge -> ball_run=1 with scores unchanged.
REQ-040 Assert reset mid-POINT countdown -> next cycle shows IDLE outputs and scores 0.
